// File: rtl/servant_spi_bus_arbiter.sv
// servant_spi_bus_arbiter
//   Merges the SERV instruction bus (read-only) and data bus (read/write) onto one
//   registered Wishbone master port feeding the SPI RAM master. A granted request is
//   held constant on m_wb_* for the whole downstream cycle. Every completion is
//   followed by idle gap cycles. A watchdog force-completes a hung cycle with error
//   data.
//
//   clock, reset            single clock, synchronous active-high reset
//   i_wb_adr/cyc            ibus request in; i_wb_rdt/ack completion out
//   d_wb_adr/dat/sel/we/cyc dbus request in; d_wb_rdt/ack completion out
//   m_wb_adr/dat/sel/we/cyc registered request to the SPI master
//   m_wb_rdt/ack            read data / completion from the SPI master
//   timeout_err             one-cycle pulse on a watchdog completion
//
//   state | meaning
//   IDLE  | waiting for a request; arbitrates and launches on the same edge
//   BUSY  | downstream cycle in flight, m_wb_* frozen, watchdog running
//   GAP   | m_wb_cyc held low for GAP_CYCLES before the next arbitration

module servant_spi_bus_arbiter #(
   parameter int ADDRESS_WIDTH  = 24,
   parameter int GAP_CYCLES     = 1,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [ADDRESS_WIDTH-3:0] i_wb_adr,
   input  logic                     i_wb_cyc,
   output logic [31:0]              i_wb_rdt,
   output logic                     i_wb_ack,
   input  logic [ADDRESS_WIDTH-3:0] d_wb_adr,
   input  logic [31:0]              d_wb_dat,
   input  logic [3:0]               d_wb_sel,
   input  logic                     d_wb_we,
   input  logic                     d_wb_cyc,
   output logic [31:0]              d_wb_rdt,
   output logic                     d_wb_ack,
   output logic [ADDRESS_WIDTH-3:0] m_wb_adr,
   output logic [31:0]              m_wb_dat,
   output logic [3:0]               m_wb_sel,
   output logic                     m_wb_we,
   output logic                     m_wb_cyc,
   input  logic [31:0]              m_wb_rdt,
   input  logic                     m_wb_ack,
   output logic                     timeout_err
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_GAP = 2'd2} state_e;
   typedef enum logic {GNT_IBUS = 1'b0, GNT_DBUS = 1'b1} grant_e;

   state_e                   state_q, state_d;
   grant_e                   owner_q, owner_d, last_grant_q, last_grant_d, grant;
   logic                     abort_q, abort_d;
   logic [TW-1:0]            timer_q, timer_d;
   logic [GW-1:0]            gap_q, gap_d;
   logic [ADDRESS_WIDTH-3:0] m_adr_q, m_adr_d;
   logic [31:0]              m_dat_q, m_dat_d;
   logic [3:0]               m_sel_q, m_sel_d;
   logic                     m_we_q, m_we_d, m_cyc_q, m_cyc_d;
   logic [31:0]              i_rdt_q, i_rdt_d, d_rdt_q, d_rdt_d;
   logic                     i_ack_q, i_ack_d, d_ack_q, d_ack_d, terr_q, terr_d;
   logic                     owner_cyc, done, timed_out;
   logic [31:0]              done_rdt;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      abort_d      = abort_q;
      timer_d      = timer_q;
      gap_d        = gap_q;
      m_adr_d      = m_adr_q;
      m_dat_d      = m_dat_q;
      m_sel_d      = m_sel_q;
      m_we_d       = m_we_q;
      m_cyc_d      = m_cyc_q;
      i_rdt_d      = i_rdt_q;
      d_rdt_d      = d_rdt_q;
      i_ack_d      = 1'b0;
      d_ack_d      = 1'b0;
      terr_d       = 1'b0;
      grant        = GNT_IBUS;
      owner_cyc    = (owner_q == GNT_DBUS) ? d_wb_cyc : i_wb_cyc;
      done         = 1'b0;
      done_rdt     = '0;
      timed_out    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (i_wb_cyc || d_wb_cyc) begin
               // contention goes to whichever master did not win last time
               if (d_wb_cyc && (!i_wb_cyc || last_grant_q == GNT_IBUS)) grant = GNT_DBUS;
               owner_d = grant;
               abort_d = 1'b0;
               timer_d = '0;
               m_cyc_d = 1'b1;
               state_d = S_BUSY;
               if (grant == GNT_DBUS) begin
                  m_adr_d = d_wb_adr;
                  m_dat_d = d_wb_dat;
                  m_sel_d = d_wb_sel;
                  m_we_d  = d_wb_we;
               end else begin
                  m_adr_d = i_wb_adr;
                  m_dat_d = '0;
                  m_sel_d = 4'hF;
                  m_we_d  = 1'b0;
               end
            end
         end
         S_BUSY: begin
            timer_d = timer_q + 1'b1;
            // sticky: a master that let go must not see this cycle's ack,
            // even if it raises a fresh request before the slave answers
            if (!owner_cyc) abort_d = 1'b1;
            timed_out = (TIMEOUT_CYCLES != 0) && (timer_q == TMO_LAST);
            if (m_wb_ack) begin
               done     = 1'b1;
               done_rdt = m_wb_rdt;
            end else if (timed_out) begin
               done     = 1'b1;
               done_rdt = 32'hFFFF_FFFF;
               terr_d   = 1'b1;
            end
            if (done) begin
               m_cyc_d      = 1'b0;
               last_grant_d = owner_q;
               timer_d      = '0;
               gap_d        = GAP_LAST;
               state_d      = S_GAP;
               if (!abort_d) begin
                  if (owner_q == GNT_DBUS) begin
                     d_ack_d = 1'b1;
                     d_rdt_d = done_rdt;
                  end else begin
                     i_ack_d = 1'b1;
                     i_rdt_d = done_rdt;
                  end
               end
            end
         end
         S_GAP: begin
            timer_d = '0;
            if (gap_q == '0) state_d = S_IDLE;
            else             gap_d   = gap_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         owner_q      <= GNT_IBUS;
         last_grant_q <= GNT_IBUS;
         abort_q      <= 1'b0;
         timer_q      <= '0;
         gap_q        <= '0;
         m_adr_q      <= '0;
         m_dat_q      <= '0;
         m_sel_q      <= '0;
         m_we_q       <= 1'b0;
         m_cyc_q      <= 1'b0;
         i_rdt_q      <= '0;
         d_rdt_q      <= '0;
         i_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         terr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         abort_q      <= abort_d;
         timer_q      <= timer_d;
         gap_q        <= gap_d;
         m_adr_q      <= m_adr_d;
         m_dat_q      <= m_dat_d;
         m_sel_q      <= m_sel_d;
         m_we_q       <= m_we_d;
         m_cyc_q      <= m_cyc_d;
         i_rdt_q      <= i_rdt_d;
         d_rdt_q      <= d_rdt_d;
         i_ack_q      <= i_ack_d;
         d_ack_q      <= d_ack_d;
         terr_q       <= terr_d;
      end
   end

   assign m_wb_adr    = m_adr_q;
   assign m_wb_dat    = m_dat_q;
   assign m_wb_sel    = m_sel_q;
   assign m_wb_we     = m_we_q;
   assign m_wb_cyc    = m_cyc_q;
   assign i_wb_rdt    = i_rdt_q;
   assign i_wb_ack    = i_ack_q;
   assign d_wb_rdt    = d_rdt_q;
   assign d_wb_ack    = d_ack_q;
   assign timeout_err = terr_q;

endmodule
